// File: rtl/gold_pkg.sv
// Shared types and constants for the gold-bag fall scheduler.
// The bag lifecycle codes and the 32-pixel cell geometry used by the scan logic are defined here.
package gold_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    localparam logic [3:0] GS_RESTING = 4'd0;
    localparam logic [3:0] GS_FALLING = 4'd1;
    localparam logic [3:0] GS_CRASHED = 4'd2;
    localparam logic [3:0] GS_EATEN   = 4'd3;

    localparam int CELL_SHIFT = 5;
    localparam int CELL_W     = 5;

    // Multiply an event count by the per-bag award, clamped at 16 bits.
    function automatic logic [15:0] sat_score(input logic [4:0] events, input int unsigned points);
        logic [63:0] prod;
        prod = 64'(events) * 64'(points);
        return (prod > 64'h0000_0000_0000_FFFF) ? 16'hFFFF : prod[15:0];
    endfunction

endpackage

// File: rtl/gold_fall_scheduler_map_req_handshake.sv
// Single outstanding map lookup: holds request and address until ack or timeout.
// Reports the ack or timeout combinationally so the scan FSM resolves the bag that same cycle.
module map_req_handshake
    import gold_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              start_i,
    input  logic [CELL_W-1:0] col_i,
    input  logic [CELL_W-1:0] row_i,
    output logic              map_req_o,
    output logic [CELL_W-1:0] map_col_o,
    output logic [CELL_W-1:0] map_row_o,
    input  logic              map_ack_i,
    input  logic              map_empty_i,
    output logic              rsp_valid_o,
    output logic              timeout_o,
    output logic              rsp_empty_o
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic              req_q, req_d;
    logic [CELL_W-1:0] col_q, col_d;
    logic [CELL_W-1:0] row_q, row_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // cnt_q counts completed wait cycles; the request is abandoned in its ACK_TIMEOUT-th cycle.
    assign rsp_valid_o = req_q & map_ack_i;
    assign timeout_o   = req_q & ~map_ack_i & (cnt_q == CNT_LAST);
    assign rsp_empty_o = map_empty_i;

    always_comb begin
        req_d = req_q;
        col_d = col_q;
        row_d = row_q;
        cnt_d = cnt_q;
        if (start_i) begin
            req_d = 1'b1;
            col_d = col_i;
            row_d = row_i;
            cnt_d = '0;
        end else if (rsp_valid_o || timeout_o) begin
            req_d = 1'b0;
        end else if (req_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            req_q <= 1'b0;
            col_q <= '0;
            row_q <= '0;
            cnt_q <= '0;
        end else begin
            req_q <= req_d;
            col_q <= col_d;
            row_q <= row_d;
            cnt_q <= cnt_d;
        end
    end

    assign map_req_o = req_q;
    assign map_col_o = col_q;
    assign map_row_o = row_q;

endmodule

// File: rtl/gold_fall_scheduler.sv
// Per-frame walk over all gold bags, asking the shared map port whether the cell below is dug out.
// Optional eaten-bag scoring is compiled in when GOLD_SCORE_EN is defined.
module gold_fall_scheduler
    import gold_pkg::*;
#(
    parameter int NUM_BAGS    = 8,
    parameter int MAP_ROWS    = 15,
    parameter int ACK_TIMEOUT = 15,
    parameter int GOLD_POINTS = 500
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic signed [10:0]   bag_topLeftX   [NUM_BAGS],
    input  logic signed [10:0]   bag_topLeftY   [NUM_BAGS],
    input  logic [3:0]           bag_gold_state [NUM_BAGS],
    output logic                 map_req,
    output logic [4:0]           map_col,
    output logic [4:0]           map_row,
    input  logic                 map_ack,
    input  logic                 map_empty,
    output logic [NUM_BAGS-1:0]  can_fall,
    output logic                 scan_done,
    output logic                 overrun,
    output logic [15:0]          score_add
);

    localparam int IDX_W = (NUM_BAGS > 1) ? $clog2(NUM_BAGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BAGS - 1);

    scan_state_t         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_BAGS-1:0] can_fall_q, can_fall_d;
    logic                scan_done_q, scan_done_d;
    logic                overrun_q, overrun_d;

    logic signed [10:0]  cur_x, cur_y;
    logic [3:0]          cur_gs;
    logic [CELL_W-1:0]   cur_col, cur_row;
    logic                skip_bag, last_bag, issue;
    logic                hs_valid, hs_timeout, hs_empty;
    logic                unused_pix;

    assign cur_x    = bag_topLeftX[idx_q];
    assign cur_y    = bag_topLeftY[idx_q];
    assign cur_gs   = bag_gold_state[idx_q];
    assign cur_col  = cur_x[CELL_SHIFT +: CELL_W];
    assign cur_row  = cur_y[CELL_SHIFT +: CELL_W];
    assign last_bag = (idx_q == LAST_IDX);
    assign unused_pix = ^{cur_x[CELL_SHIFT-1:0], cur_y[CELL_SHIFT-1:0]};

    // Crashed/eaten bags, off-screen bags and bags on the bottom row never query the map.
    assign skip_bag = (cur_gs == GS_CRASHED) || (cur_gs == GS_EATEN) ||
                      cur_x[10] || cur_y[10] ||
                      ({27'd0, cur_row} >= 32'(MAP_ROWS - 1));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        can_fall_d = can_fall_q;
        issue      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (startOfFrame) begin
                    idx_d   = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (skip_bag) begin
                    can_fall_d[idx_q] = 1'b0;
                    idx_d             = idx_q + 1'b1;
                    state_d           = last_bag ? ST_DONE : ST_CHECK;
                end else begin
                    issue   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (hs_valid || hs_timeout) begin
                    can_fall_d[idx_q] = hs_valid & hs_empty;
                    idx_d             = idx_q + 1'b1;
                    state_d           = last_bag ? ST_DONE : ST_CHECK;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // scan_done is registered on entry so it is high during the single DONE cycle.
        scan_done_d = (state_q != ST_DONE) && (state_d == ST_DONE);
        overrun_d   = startOfFrame && (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            can_fall_q  <= '0;
            scan_done_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            can_fall_q  <= can_fall_d;
            scan_done_q <= scan_done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign can_fall  = can_fall_q;
    assign scan_done = scan_done_q;
    assign overrun   = overrun_q;

    map_req_handshake #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_handshake (
        .clk         (clk),
        .resetN      (resetN),
        .start_i     (issue),
        .col_i       (cur_col),
        .row_i       (cur_row + 1'b1),
        .map_req_o   (map_req),
        .map_col_o   (map_col),
        .map_row_o   (map_row),
        .map_ack_i   (map_ack),
        .map_empty_i (map_empty),
        .rsp_valid_o (hs_valid),
        .timeout_o   (hs_timeout),
        .rsp_empty_o (hs_empty)
    );

`ifdef GOLD_SCORE_EN
    logic [3:0]          prev_state_q [NUM_BAGS];
    logic [NUM_BAGS-1:0] eaten_evt;
    logic [4:0]          evt_cnt;
    logic [15:0]         score_q, score_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_BAGS; i++) prev_state_q[i] <= GS_RESTING;
        end else begin
            for (int i = 0; i < NUM_BAGS; i++) prev_state_q[i] <= bag_gold_state[i];
        end
    end

    for (genvar gi = 0; gi < NUM_BAGS; gi++) begin : g_evt
        assign eaten_evt[gi] = (prev_state_q[gi] == GS_CRASHED) && (bag_gold_state[gi] == GS_EATEN);
    end

    always_comb begin
        evt_cnt = '0;
        for (int i = 0; i < NUM_BAGS; i++) evt_cnt = evt_cnt + 5'(eaten_evt[i]);
        score_d = sat_score(evt_cnt, GOLD_POINTS);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) score_q <= '0;
        else         score_q <= score_d;
    end

    assign score_add = score_q;
`else
    assign score_add = '0;
`endif

endmodule

// File: tb/tb_gold_fall_scheduler.sv
// Scoreboard bench for gold_fall_scheduler: stimulus pushes expected requests, scan results,
// overrun and score events; a negedge monitor pops and compares whenever the DUT presents one.
module tb_gold_fall_scheduler;

    localparam int NB = 4;

    logic                clk = 1'b0;
    logic                resetN = 1'b1;
    logic                sof = 1'b0;
    logic signed [10:0]  bx [NB];
    logic signed [10:0]  by [NB];
    logic [3:0]          gs [NB];
    logic                map_req;
    logic [4:0]          map_col, map_row;
    logic                map_ack = 1'b0;
    logic                map_empty = 1'b0;
    logic [NB-1:0]       can_fall;
    logic                scan_done, overrun;
    logic [15:0]         score_add;

    always #5 clk = ~clk;

    gold_fall_scheduler #(
        .NUM_BAGS    (NB),
        .MAP_ROWS    (15),
        .ACK_TIMEOUT (15),
        .GOLD_POINTS (500)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (sof),
        .bag_topLeftX   (bx),
        .bag_topLeftY   (by),
        .bag_gold_state (gs),
        .map_req        (map_req),
        .map_col        (map_col),
        .map_row        (map_row),
        .map_ack        (map_ack),
        .map_empty      (map_empty),
        .can_fall       (can_fall),
        .scan_done      (scan_done),
        .overrun        (overrun),
        .score_add      (score_add)
    );

    typedef struct { logic [4:0] col; logic [4:0] row; int len; } req_exp_t;
    typedef struct { logic [NB-1:0] cf; int elapsed; } done_exp_t;

    req_exp_t    req_sb   [$];
    done_exp_t   done_sb  [$];
    int          ovr_sb   [$];
    logic [15:0] score_sb [$];

    int vectors = 0, miscompares = 0;
    int cyc = 0, sof_cyc = 0, done_cnt = 0;
    logic [31:0] empty_cols = '0, noack_cols = '0;
    int ack_lat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Map model: acks ack_lat cycles after map_req is first seen, except for blocked columns.
    int age = 0;
    always @(negedge clk) begin
        map_ack = 1'b0;
        if (map_req === 1'b1) begin
            age++;
            if (!noack_cols[map_col] && age == ack_lat + 1) begin
                map_ack   = 1'b1;
                map_empty = empty_cols[map_col];
            end
        end else begin
            age = 0;
        end
    end

    // Monitor
    logic     req_prev = 1'b0;
    int       req_len = 0;
    req_exp_t cur_req;
    always @(negedge clk) begin
        if (map_req === 1'b1) begin
            if (!req_prev) begin
                req_len = 0;
                if (req_sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL map_req: unexpected request col=%0d row=%0d, none required", map_col, map_row);
                    cur_req = '{col: 5'd0, row: 5'd0, len: -1};
                end else begin
                    cur_req = req_sb.pop_front();
                    chk("req_col", 32'(map_col), 32'(cur_req.col));
                    chk("req_row", 32'(map_row), 32'(cur_req.row));
                end
            end
            req_len++;
        end else if (req_prev && cur_req.len >= 0) begin
            chk("req_len", 32'(req_len), 32'(cur_req.len));
        end
        req_prev = (map_req === 1'b1);

        if (scan_done === 1'b1) begin
            done_cnt++;
            if (done_sb.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL scan_done: unexpected pulse, can_fall=%b", can_fall);
            end else begin
                done_exp_t d;
                d = done_sb.pop_front();
                chk("can_fall", 32'(can_fall), 32'(d.cf));
                chk("done_latency", 32'(cyc - sof_cyc), 32'(d.elapsed));
            end
        end

        if (overrun === 1'b1) begin
            if (ovr_sb.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL overrun: unexpected pulse at cycle %0d", cyc);
            end else begin
                void'(ovr_sb.pop_front());
                chk("overrun", 32'(overrun), 32'd1);
            end
        end

        if (score_add !== 16'd0) begin
            if (score_sb.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL score_add: got %0d required 0", score_add);
            end else begin
                logic [15:0] s;
                s = score_sb.pop_front();
                chk("score_add", 32'(score_add), 32'(s));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_sof(input bit record);
        @(negedge clk);
        sof = 1'b1;
        if (record) sof_cyc = cyc;
        @(negedge clk);
        sof = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start_cnt;
        int n;
        start_cnt = done_cnt;
        n = 0;
        while (done_cnt == start_cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == start_cnt) begin
            vectors++; miscompares++;
            $display("FAIL scan_done_wait: no pulse within %0d cycles", budget);
        end
    endtask

    task automatic push_req(input int col, input int row, input int len);
        req_sb.push_back('{col: 5'(col), row: 5'(row), len: len});
    endtask

    task automatic push_done(input logic [NB-1:0] cf, input int el);
        done_sb.push_back('{cf: cf, elapsed: el});
    endtask

    // Bags 0..2 resting at row 5 in columns 0..2; bag 3 off-screen above.
    task automatic bags_std();
        for (int i = 0; i < 3; i++) begin
            bx[i] = 11'(i * 32);
            by[i] = 11'sd160;
            gs[i] = 4'd0;
        end
        bx[3] = 11'sd0;
        by[3] = -11'sd32;
        gs[3] = 4'd0;
    endtask

    // Every cell empty, immediate ack: each queried bag costs 2 cycles, skip costs 1.
    task automatic scan_all_empty();
        bags_std();
        empty_cols = '1; noack_cols = '0; ack_lat = 0;
        push_req(0, 6, 1); push_req(1, 6, 1); push_req(2, 6, 1);
        push_done(4'b0111, 8);
        pulse_sof(1'b1);
        wait_done(200);
    endtask

    initial begin
        logic [15:0] exp_score;
        bags_std();
        #1 resetN = 1'b0;
        tick(2);
        chk("rst_map_req", 32'(map_req), 32'd0);
        chk("rst_map_addr", {22'd0, map_col, map_row}, 32'd0);
        chk("rst_can_fall", 32'(can_fall), 32'd0);
        chk("rst_pulses", {30'd0, scan_done, overrun}, 32'd0);
        chk("rst_score", 32'(score_add), 32'd0);
        @(negedge clk) resetN = 1'b1;
        tick(2);

        scan_all_empty();

        // Only column 1 empty, 2-cycle ack latency: 3 x 4 cycles + skipped bag 3 + 1.
        bags_std();
        empty_cols = 32'h2; ack_lat = 2;
        push_req(0, 6, 3); push_req(1, 6, 3); push_req(2, 6, 3);
        push_done(4'b0010, 14);
        pulse_sof(1'b1);
        wait_done(200);
        tick(3);

        // Crashed bag 0, bag 2 on row 14, bag 3 with negative X: only bag 1 queried.
        scan_all_empty();
        bags_std();
        gs[0] = 4'd2; by[2] = 11'sd448; bx[3] = -11'sd1; by[3] = 11'sd160;
        empty_cols = '1; ack_lat = 2;
        push_req(1, 6, 3);
        push_done(4'b0010, 8);
        pulse_sof(1'b1);
        wait_done(200);
        gs[0] = 4'd0;
        tick(3);

        // Column 0 never acks (15-cycle request); bag 2 on row 13 still queried.
        scan_all_empty();
        bags_std();
        by[2] = 11'sd416;
        empty_cols = '1; noack_cols = 32'h1; ack_lat = 0;
        push_req(0, 6, 15); push_req(1, 6, 1); push_req(2, 14, 1);
        push_done(4'b0110, 22);
        pulse_sof(1'b1);
        wait_done(200);
        tick(3);

        // Second startOfFrame mid-scan: one overrun pulse, no restart, no second scan.
        bags_std();
        empty_cols = '1; noack_cols = '0; ack_lat = 2;
        push_req(0, 6, 3); push_req(1, 6, 3); push_req(2, 6, 3);
        push_done(4'b0111, 14);
        ovr_sb.push_back(1);
        pulse_sof(1'b1);
        tick(4);
        pulse_sof(1'b0);
        wait_done(200);
        tick(40);

        // Score: bags 0 and 3 crashed->eaten together, then bag 1 alone with bag 2 resting->eaten.
        gs[0] = 4'd2; gs[3] = 4'd2;
        tick(3);
`ifdef GOLD_SCORE_EN
        exp_score = 16'd1000;
        score_sb.push_back(exp_score);
`else
        exp_score = 16'd0;
`endif
        gs[0] = 4'd3; gs[3] = 4'd3;
        tick(1);
        chk("score_pair", 32'(score_add), 32'(exp_score));
        tick(1);
        chk("score_pulse_end", 32'(score_add), 32'd0);
        gs[1] = 4'd2;
        tick(2);
`ifdef GOLD_SCORE_EN
        exp_score = 16'd500;
        score_sb.push_back(exp_score);
`else
        exp_score = 16'd0;
`endif
        gs[1] = 4'd3; gs[2] = 4'd3;
        tick(1);
        chk("score_single", 32'(score_add), 32'(exp_score));
        bags_std();
        tick(3);

        // Asynchronous reset during WAIT, then a fresh scan from bag 0.
        scan_all_empty();
        noack_cols = '1;
        push_req(0, 6, 3);
        pulse_sof(1'b1);
        tick(3);
        #2 resetN = 1'b0;
        #1;
        chk("rst_wait_map_req", 32'(map_req), 32'd0);
        chk("rst_wait_can_fall", 32'(can_fall), 32'd0);
        tick(2);
        resetN = 1'b1;
        tick(2);
        scan_all_empty();
        tick(5);

        chk("left_req", 32'(req_sb.size()), 32'd0);
        chk("left_done", 32'(done_sb.size()), 32'd0);
        chk("left_overrun", 32'(ovr_sb.size()), 32'd0);
        chk("left_score", 32'(score_sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
